// File: rtl/i3226_activity_monitor_pkg.sv
// i3226_mon_pkg: pattern state type, detect pattern constant and saturating increment for the I3226 monitor
package i3226_mon_pkg;
  localparam int MAX_W = 13;
  localparam logic [3:0] PATTERN = 4'b1011;
  typedef enum logic [1:0] {IDLE, S1, S10, S101} pat_state_t;
  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v, input logic inc, input logic [MAX_W-1:0] max);
    return (inc && v != max) ? v + 1'b1 : v;
  endfunction
endpackage

// File: rtl/i3226_activity_monitor_if.sv
// i3226_activity_monitor_if: bundles I3226/mon_en/alarm_clr inputs and edge_cnt/win_done/alarm/pat_hit outputs; slave = monitor side
interface i3226_activity_monitor_if #(parameter int WINDOW = 64);
  localparam int CNT_W = $clog2(WINDOW + 1);
  logic I3226, mon_en, alarm_clr, win_done, alarm, pat_hit;
  logic [CNT_W-1:0] edge_cnt;
  modport master(output I3226, mon_en, alarm_clr, input edge_cnt, win_done, alarm, pat_hit);
  modport slave(input I3226, mon_en, alarm_clr, output edge_cnt, win_done, alarm, pat_hit);
endinterface

// File: rtl/i3226_activity_monitor_window.sv
// i3226_mon_window: window/live edge counters; ports clk, rst, en, edge_in -> edge_cnt snapshot, win_done pulse, thr_hit (comb set request)
module i3226_mon_window
  import i3226_mon_pkg::*;
#(
  parameter int WINDOW = 64,
  parameter int THRESH = 8,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             edge_in,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             win_done,
  output logic             thr_hit
);
  localparam int WC_W = $clog2(WINDOW);
  logic [WC_W-1:0] wcnt;
  logic [CNT_W-1:0] live, nxt;
  logic last;
  always_comb begin
    nxt = CNT_W'(sat_inc(MAX_W'(live), edge_in, MAX_W'({CNT_W{1'b1}})));
    last = en && wcnt == WC_W'(WINDOW - 1);
    thr_hit = last && nxt >= CNT_W'(THRESH);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wcnt <= '0;
      live <= '0;
      edge_cnt <= '0;
      win_done <= 1'b0;
    end else begin
      win_done <= last;
      if (last) begin
        edge_cnt <= nxt;
        live <= '0;
        wcnt <= '0;
      end else if (en) begin
        live <= nxt;
        wcnt <= wcnt + 1'b1;
      end
    end
endmodule

// File: rtl/i3226_activity_monitor.sv
// i3226_activity_monitor: I3226 edge-rate monitor; ports I1294_clk, I1301_rst (async), mon (slave modport); I3226_MON_PATTERN_EN enables 1011 detector
module i3226_activity_monitor
  import i3226_mon_pkg::*;
#(
  parameter int WINDOW = 64,
  parameter int THRESH = 8
) (
  input logic I1294_clk,
  input logic I1301_rst,
  i3226_activity_monitor_if.slave mon
);
  localparam int CNT_W = $clog2(WINDOW + 1);
  logic s0, s1, edge_w, thr_hit;
  assign edge_w = mon.mon_en & s0 & ~s1;
  i3226_mon_window #(.WINDOW(WINDOW), .THRESH(THRESH), .CNT_W(CNT_W)) u_win (
    .clk(I1294_clk),
    .rst(I1301_rst),
    .en(mon.mon_en),
    .edge_in(edge_w),
    .edge_cnt(mon.edge_cnt),
    .win_done(mon.win_done),
    .thr_hit(thr_hit)
  );
  always_ff @(posedge I1294_clk or posedge I1301_rst)
    if (I1301_rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      mon.alarm <= 1'b0;
    end else begin
      s0 <= mon.I3226;
      if (mon.mon_en) s1 <= s0;
      mon.alarm <= thr_hit | (mon.alarm & ~mon.alarm_clr);
    end
`ifdef I3226_MON_PATTERN_EN
  pat_state_t st;
  always_ff @(posedge I1294_clk or posedge I1301_rst)
    if (I1301_rst) begin
      st <= IDLE;
      mon.pat_hit <= 1'b0;
    end else begin
      mon.pat_hit <= mon.mon_en && st == S101 && s0 == PATTERN[0];
      if (mon.mon_en)
        case (st)
          IDLE:    st <= s0 ? S1 : IDLE;
          S1:      st <= s0 ? S1 : S10;
          S10:     st <= s0 ? S101 : IDLE;
          default: st <= s0 ? S1 : S10;
        endcase
    end
`else
  assign mon.pat_hit = 1'b0;
`endif
endmodule

// File: doc/i3226_activity_monitor.md
# i3226_activity_monitor

Downstream observation stage for the I3226 subcircuit output: samples the single-bit I3226 net every clock and counts its rising edges over fixed windows. It raises a sticky alarm when a window's edge count reaches a threshold, and optionally detects the rare serial pattern 1-0-1-1 on the sampled stream. It sits directly after the I3226 subcircuit in the trojan-detection benchmark harness and shares that subcircuit's clock and reset nets.

## Interface
- WINDOW, 64: window length in enabled cycles; legal range 2..4096.
- THRESH, 8: edge count at or above which alarm sets; legal range 1..WINDOW.
- CNT_W, derived $clog2(WINDOW+1): edge counter width; not overridden.
- I1294_clk  in  1  single clock; all state updates on rising edge.
- I1301_rst  in  1  asynchronous, active-high reset.
- I3226  in  1  upstream subcircuit output; no other timing assumption; registered on entry.
- mon_en  in  1  advances window, edge counting and pattern FSM when 1; all state holds when 0.
- alarm_clr  in  1  synchronous clear of the sticky alarm.
- edge_cnt  out  CNT_W  edge count of the last completed window.
- win_done  out  1  one-cycle pulse when a window completes.
- alarm  out  1  sticky threshold alarm.
- pat_hit  out  1  one-cycle pulse on a 1-0-1-1 detection; tied 0 when the pattern feature is compiled out.

## Operation
- Input capture: s0 <= I3226 every cycle, independent of mon_en; s1 <= s0 only when mon_en=1; edge = mon_en & s0 & ~s1.
- Live counter: incremented by edge and saturating at 2^CNT_W-1.
- Window counter: counts mon_en cycles 0..WINDOW-1. On the enabled cycle where it equals WINDOW-1:
  - Snapshot edge_cnt <= live + edge.
  - Set win_done.
  - Reset live and the window counter to 0.
- Alarm: sets on the same edge as the snapshot if live+edge >= THRESH. Clears on alarm_clr. Set and clr in the same cycle: set wins.
- Pattern FSM, stepped on the s0 value only when mon_en=1; overlapping detection:
  - IDLE: 1 goes to S1; 0 stays in IDLE.
  - S1: 0 goes to S10; 1 stays in S1.
  - S10: 1 goes to S101; 0 goes to IDLE.
  - S101: 1 pulses pat_hit and goes to S1; 0 goes to S10.
- mon_en=0 freezes s1, the live counter, the window counter and FSM state. win_done and pat_hit are 0 on any cycle with mon_en=0.

## Timing
- Reset values: s0, s1, the live counter, the window counter, edge_cnt, win_done, alarm and pat_hit are all 0; FSM state is IDLE.
- Reset is asynchronous and takes effect immediately, including mid-window. The first window after reset release starts at window count 0.
- Latency:
  - A rising edge on I3226 before clock edge n is in s0 after n.
  - That edge is counted at clock edge n+1, provided s1 was 0 and mon_en=1.
- win_done, edge_cnt and the alarm set are all registered and change at the same clock edge.
- pat_hit is registered: it asserts the cycle after the s0 value that completes the pattern.
- Final-cycle edge: an edge on the last cycle of a window is included in that window's snapshot, not the next window's.
- alarm_clr alone clears alarm at the next clock edge.

## Configuration
- I3226_MON_PATTERN_EN defined: the pattern FSM is instantiated and pat_hit is driven as described in Operation.
- I3226_MON_PATTERN_EN undefined: no FSM flops are instantiated and pat_hit is a constant 0. Counting and alarm behaviour are unchanged.

## Structure
- Package i3226_mon_pkg contains:
  - The pattern state enum: IDLE, S1, S10, S101 (2 bits).
  - The pattern constant 4'b1011.
  - A saturating-increment function.
- One sub-module, i3226_mon_window. It holds the window counter and live counter and produces the snapshot, win_done and the threshold compare. The top level holds the input capture, the alarm and the FSM.

## Test plan
- Reset check: assert I1301_rst mid-window with live=5 -> all outputs 0 immediately. After release, the next win_done pulse comes exactly WINDOW=64 enabled cycles later.
- Threshold crossing: 8 isolated pulses in one 64-cycle window -> win_done with edge_cnt=8 and alarm=1. Next window with 7 pulses -> edge_cnt=7, alarm stays 1.
- Clear vs set: alarm_clr in the same cycle as a qualifying snapshot -> alarm remains 1. alarm_clr alone one cycle later -> alarm=0.
- Boundary edge: single edge on window cycle 63 -> edge_cnt=1 in that snapshot; next window snapshot edge_cnt=0.
- Enable gating: hold I3226 high and toggle mon_en 0 for 10 cycles mid-window -> no extra edges counted; window completes 10 cycles later than without gating.
- Pattern (macro defined): stream 1,0,1,1,0,1,1 -> two pat_hit pulses, one cycle after the 4th and 7th bits. Macro undefined -> pat_hit constantly 0.
